writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 26 ++
 rtl/rs_constants.v | 6 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/writeback_arbiter.sv | 117 +++++++++++
 tb/tb_writeback_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Types and helpers shared by the writeback arbiter and its lane FIFOs.
`include "rs_constants.v"

package writeback_arbiter_pkg;

  localparam int PREG_W   = `PREG_WIDTH;
  localparam int WB_DEPTH = `WB_FIFO_DEPTH;
  localparam int DATA_W   = 32;

  // Lane index 0..2
  typedef logic [1:0] lane_t;

  // One buffered result: destination tag plus data
  typedef struct packed {
    logic [PREG_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // (base + k) mod 3, used for the round-robin scan order
  function automatic lane_t lane_add(lane_t base, int k);
    int s;
    s = int'(base) + k;
    return lane_t'(s % 3);
  endfunction

endpackage

// File: rtl/rs_constants.v
// Shared reservation-station / writeback constants.
`ifndef RS_CONSTANTS_V
`define RS_CONSTANTS_V
`define PREG_WIDTH 6
`define WB_FIFO_DEPTH 4
`endif

// File: rtl/wb_fifo.sv
// Per-lane result FIFO: circular buffer, full/empty decided by occupancy.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int  DEPTH = WB_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [OCC_W-1:0] occ_o,
  output logic             full_o,
  output logic             empty_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push is only honoured with room; a pop only with data
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy bookkeeping: simultaneous push and pop leaves it unchanged
  always_comb begin
    occ_d = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; clearing occupancy already makes every slot invalid.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Three-lane writeback arbiter: buffers lane results and grants up to two
// register-file write ports per cycle in round-robin order.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_DEPTH,
  parameter int NUM_LANES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       res0,
  input  logic [31:0]       res1,
  input  logic [31:0]       res2,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic [PREG_W-1:0] rd0,
  input  logic [PREG_W-1:0] rd1,
  input  logic [PREG_W-1:0] rd2,
  output logic              ready0,
  output logic              ready1,
  output logic              ready2,
  output logic              wb_valid0,
  output logic              wb_valid1,
  output logic [PREG_W-1:0] wb_tag0,
  output logic [PREG_W-1:0] wb_tag1,
  output logic [31:0]       wb_data0,
  output logic [31:0]       wb_data1,
  output logic [2:0]        occ0,
  output logic [2:0]        occ1,
  output logic [2:0]        occ2
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t            lane_in [NUM_LANES];
  wb_entry_t            head    [NUM_LANES];
  logic [OCC_W-1:0]     occ     [NUM_LANES];
  logic [NUM_LANES-1:0] valid_v, push, pop, full, empty;
  lane_t                order   [NUM_LANES];
  lane_t                rr_q, rr_d;
  wb_entry_t            port0, port1;
  logic                 v0, v1;

  assign lane_in[0] = '{tag: rd0, data: res0};
  assign lane_in[1] = '{tag: rd1, data: res1};
  assign lane_in[2] = '{tag: rd2, data: res2};
  assign valid_v    = {valid2, valid1, valid0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    // Tag 0 is accepted by the handshake but never stored
    assign push[g] = valid_v[g] && !full[g] && (lane_in[g].tag != '0);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .push_i      (push[g]),
      .push_data_i (lane_in[g]),
      .pop_i       (pop[g]),
      .head_o      (head[g]),
      .occ_o       (occ[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g])
    );
  end

  // Scan order starting at the round-robin pointer
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) order[k] = lane_add(rr_q, k);
  end

  // First non-empty lane in scan order drives port 0, the second drives port 1
  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves one unassigned (no latch).
    port0 = '0;
    port1 = '0;
    v0    = 1'b0;
    v1    = 1'b0;
    pop   = '0;
    rr_d  = rr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!empty[order[k]]) begin
        if (!v0) begin
          v0             = 1'b1;
          port0          = head[order[k]];
          pop[order[k]]  = 1'b1;
          rr_d           = lane_add(order[k], 1);
        end else if (!v1) begin
          v1             = 1'b1;
          port1          = head[order[k]];
          pop[order[k]]  = 1'b1;
          rr_d           = lane_add(order[k], 1);
        end
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end

  assign ready0    = !full[0];
  assign ready1    = !full[1];
  assign ready2    = !full[2];
  assign wb_valid0 = v0;
  assign wb_valid1 = v1;
  assign wb_tag0   = port0.tag;
  assign wb_tag1   = port1.tag;
  assign wb_data0  = port0.data;
  assign wb_data1  = port1.data;
  assign occ0      = 3'(occ[0]);
  assign occ1      = 3'(occ[1]);
  assign occ2      = 3'(occ[2]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: inputs change on the falling edge,
// outputs are compared on the falling edge after each rising edge.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic              clk, rst;
  logic [31:0]       res0, res1, res2;
  logic              valid0, valid1, valid2;
  logic [PREG_W-1:0] rd0, rd1, rd2;
  logic              ready0, ready1, ready2;
  logic              wb_valid0, wb_valid1;
  logic [PREG_W-1:0] wb_tag0, wb_tag1;
  logic [31:0]       wb_data0, wb_data1;
  logic [2:0]        occ0, occ1, occ2;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic [31:0] lane2_seen [$];

  writeback_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .res0(res0), .res1(res1), .res2(res2),
    .valid0(valid0), .valid1(valid1), .valid2(valid2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .ready0(ready0), .ready1(ready1), .ready2(ready2),
    .wb_valid0(wb_valid0), .wb_valid1(wb_valid1),
    .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .occ0(occ0), .occ1(occ1), .occ2(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every lane-2 result (data tagged 0x2222 in the upper half) seen on a port
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_valid0 && wb_data0[31:16] == 16'h2222) lane2_seen.push_back(wb_data0);
      if (wb_valid1 && wb_data1[31:16] == 16'h2222) lane2_seen.push_back(wb_data1);
    end
  end

  task automatic idle_inputs();
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    rd0 = '0; rd1 = '0; rd2 = '0;
    res0 = '0; res1 = '0; res2 = '0;
  endtask

  // Ends on a falling edge with reset just released
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive all three lanes with push number i
  task automatic drive_all(input int i);
    valid0 = 1'b1; rd0 = PREG_W'(i);      res0 = {16'h0000, 16'(i)};
    valid1 = 1'b1; rd1 = PREG_W'(16 + i); res1 = {16'h1111, 16'(i)};
    valid2 = 1'b1; rd2 = PREG_W'(32 + i); res2 = {16'h2222, 16'(i)};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({ready2, ready1, ready0, occ2, occ1, occ0} !== {3'b111, 9'd0}) begin
      errors++;
      $display("FAIL reset_ready_occ: got ready=%b%b%b occ=%0d/%0d/%0d exp ready=111 occ=0/0/0",
               ready2, ready1, ready0, occ2, occ1, occ0);
    end
    checks++;
    if ({wb_valid0, wb_valid1, wb_tag0, wb_tag1, wb_data0, wb_data1} !== '0) begin
      errors++;
      $display("FAIL reset_wb: got v=%b%b tag=%0d/%0d data=%h/%h exp all zero",
               wb_valid0, wb_valid1, wb_tag0, wb_tag1, wb_data0, wb_data1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Single lane-0 result; must be called on a falling edge with idle lanes
  task automatic test_single(input string tag);
    valid0 = 1'b1; rd0 = PREG_W'(5); res0 = 32'hAAAA0001;
    #1;
    checks++;
    if ({wb_valid0, ready0} !== 2'b01) begin
      errors++;
      $display("FAIL %s_no_comb_path: got wb_valid0=%b ready0=%b exp 0/1", tag, wb_valid0, ready0);
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if ({wb_valid0, wb_tag0, wb_data0} !== {1'b1, PREG_W'(5), 32'hAAAA0001}) begin
      errors++;
      $display("FAIL %s_port0: got %b/%0d/%h exp 1/5/aaaa0001", tag, wb_valid0, wb_tag0, wb_data0);
    end
    checks++;
    if ({wb_valid1, wb_tag1, wb_data1, occ0} !== {1'b0, PREG_W'(0), 32'h0, 3'd1}) begin
      errors++;
      $display("FAIL %s_port1_occ: got %b/%0d/%h occ0=%0d exp 0/0/0 occ0=1",
               tag, wb_valid1, wb_tag1, wb_data1, occ0);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid0, occ0} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL %s_drained: got wb_valid0=%b occ0=%0d exp 0/0", tag, wb_valid0, occ0);
    end
  endtask

  task automatic test_all_lanes();
    apply_reset();
    valid0 = 1'b1; rd0 = PREG_W'(1); res0 = 32'h0000_00A0;
    valid1 = 1'b1; rd1 = PREG_W'(2); res1 = 32'h0000_00A1;
    valid2 = 1'b1; rd2 = PREG_W'(3); res2 = 32'h0000_00A2;
    @(negedge clk);
    idle_inputs();
    checks++;
    if ({wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1} !==
        {1'b1, PREG_W'(1), 32'hA0, 1'b1, PREG_W'(2), 32'hA1}) begin
      errors++;
      $display("FAIL three_cycle1: got %b/%0d/%h %b/%0d/%h exp 1/1/a0 1/2/a1",
               wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1} !==
        {1'b1, PREG_W'(3), 32'hA2, 1'b0, PREG_W'(0), 32'h0}) begin
      errors++;
      $display("FAIL three_cycle2: got %b/%0d/%h %b/%0d/%h exp 1/3/a2 0/0/0",
               wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid0, occ0, occ1, occ2} !== {1'b0, 9'd0}) begin
      errors++;
      $display("FAIL three_empty: got wb_valid0=%b occ=%0d/%0d/%0d exp 0 occ=0/0/0",
               wb_valid0, occ0, occ1, occ2);
    end
    // Pointer back at lane 0: lanes 0 and 2 together must put lane 0 on port 0
    valid0 = 1'b1; rd0 = PREG_W'(9);  res0 = 32'h0000_0009;
    valid2 = 1'b1; rd2 = PREG_W'(10); res2 = 32'h0000_000A;
    @(negedge clk);
    idle_inputs();
    checks++;
    if ({wb_tag0, wb_tag1} !== {PREG_W'(9), PREG_W'(10)}) begin
      errors++;
      $display("FAIL three_rr_after: got tags %0d/%0d exp 9/10", wb_tag0, wb_tag1);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_lane2();
    apply_reset();
    lane2_seen.delete();
    mon_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_all(i);
      @(negedge clk);
    end
    checks++;
    if ({occ0, occ1, occ2} !== {3'd3, 3'd3, 3'd4}) begin
      errors++;
      $display("FAIL fill_occ: got %0d/%0d/%0d exp 3/3/4", occ0, occ1, occ2);
    end
    checks++;
    if ({ready0, ready1, ready2} !== 3'b110) begin
      errors++;
      $display("FAIL fill_ready: got %b%b%b exp 110", ready0, ready1, ready2);
    end
    // Present a ninth lane-2 result while full: it must be dropped
    idle_inputs();
    valid2 = 1'b1; rd2 = PREG_W'(41); res2 = 32'h2222_0009;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (occ2 !== 3'd3) begin
      errors++;
      $display("FAIL fill_drop: got occ2=%0d exp 3", occ2);
    end
    repeat (16) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if ({occ0, occ1, occ2} !== 9'd0) begin
      errors++;
      $display("FAIL fill_drain_occ: got %0d/%0d/%0d exp 0/0/0", occ0, occ1, occ2);
    end
    checks++;
    if (lane2_seen.size() != 8) begin
      errors++;
      $display("FAIL fill_count: got %0d lane-2 results exp 8", lane2_seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lane2_seen[i] !== {16'h2222, 16'(i + 1)}) begin
          errors++;
          $display("FAIL fill_order[%0d]: got %h exp %h", i, lane2_seen[i], {16'h2222, 16'(i + 1)});
        end
      end
    end
  endtask

  task automatic test_rd_zero();
    apply_reset();
    valid1 = 1'b1; rd1 = '0; res1 = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({ready1, occ1, wb_valid0, wb_valid1} !== {1'b1, 3'd0, 2'b00}) begin
        errors++;
        $display("FAIL rd_zero[%0d]: got ready1=%b occ1=%0d wb_valid=%b%b exp 1/0/00",
                 c, ready1, occ1, wb_valid0, wb_valid1);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 7; i++) begin
      drive_all(i);
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if ({occ0, wb_valid0} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL mid_before: got occ0=%0d wb_valid0=%b exp 3/1", occ0, wb_valid0);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({occ0, occ1, occ2, wb_valid0, wb_valid1, ready0, ready1, ready2} !== {9'd0, 2'b00, 3'b111}) begin
      errors++;
      $display("FAIL mid_async: got occ=%0d/%0d/%0d wb_valid=%b%b ready=%b%b%b exp 0/0/0 00 111",
               occ0, occ1, occ2, wb_valid0, wb_valid1, ready0, ready1, ready2);
    end
    @(negedge clk);
    rst = 1'b1;
    test_single("mid_after");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      valid0 = 1'b1; rd0 = PREG_W'(k);      res0 = {16'h0A0A, 16'(k)};
      valid2 = 1'b1; rd2 = PREG_W'(20 + k); res2 = {16'h0C0C, 16'(k)};
      @(negedge clk);
      checks++;
      if ({wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1} !==
          {1'b1, PREG_W'(k), 16'h0A0A, 16'(k), 1'b1, PREG_W'(20 + k), 16'h0C0C, 16'(k)}) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b/%0d/%h %b/%0d/%h exp 1/%0d 1/%0d",
                 k, wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1, k, 20 + k);
      end
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({wb_valid0, wb_valid1} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drained: got wb_valid=%b%b exp 00", wb_valid0, wb_valid1);
    end
    valid1 = 1'b1; rd1 = PREG_W'(7); res1 = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    checks++;
    if ({wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1} !==
        {1'b1, PREG_W'(7), 32'h12345678, 1'b0, PREG_W'(0), 32'h0}) begin
      errors++;
      $display("FAIL lane1_only: got %b/%0d/%h %b/%0d/%h exp 1/7/12345678 0/0/0",
               wb_valid0, wb_tag0, wb_data0, wb_valid1, wb_tag1, wb_data1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_all_lanes();
    test_fill_lane2();
    test_rd_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
